johnson_counter_param: RTL and testbench

Parametrised Johnson (twisted-ring) counter producing a WIDTH-bit code that steps through 2*WIDTH states, with direction control, clock enable, synchronous phase load, a decoded binary phase index and a wrap strobe. It serves as the general-purpose phase/sequence generator for timing-strobe and multiphase-enable logic, replacing fixed 4-bit ring counters.

---
 rtl/johnson_counter_param_if.sv | 35 +++
 rtl/johnson_counter_param.sv | 130 +++++++++++++
 tb/tb_johnson_counter_param.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/johnson_counter_param_if.sv
// ============================================================================
//  Module      : johnson_counter_param_if
//  Description : Control/status bundle for the parametrised Johnson counter.
//                master drives step/load controls, slave returns the code,
//                decoded phase and the wrap/illegal strobes.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface johnson_counter_param_if #(
   parameter int WIDTH = 4
) ();
   localparam int PW = $clog2(2 * WIDTH);

   logic             en;
   logic             dir;
   logic             load;
   logic [PW-1:0]    load_phase;
   logic [WIDTH-1:0] count;
   logic [PW-1:0]    phase;
   logic             wrap;
   logic             illegal;

   modport master (
      output en, dir, load, load_phase,
      input  count, phase, wrap, illegal
   );

   modport slave (
      input  en, dir, load, load_phase,
      output count, phase, wrap, illegal
   );
endinterface

`default_nettype wire

// File: rtl/johnson_counter_param.sv
// ============================================================================
//  Module      : johnson_counter_param
//  Description : WIDTH-bit Johnson (twisted-ring) counter, 2*WIDTH states,
//                with direction, enable, synchronous phase load, binary phase
//                decode and a wrap strobe. Define JOHNSON_SELF_CORRECT_EN to
//                detect illegal codes, force them to 0 and pulse illegal.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module johnson_counter_param #(
   parameter int WIDTH = 4
) (
   input  wire logic               clk,
   input  wire logic               rst,
   johnson_counter_param_if.slave  bus
);
   localparam int               PW     = $clog2(2 * WIDTH);
   localparam logic [WIDTH-1:0] C_ONES = '1;
   localparam logic [31:0]      C_LEN  = 32'(2 * WIDTH);

   logic [WIDTH-1:0] r_count;
   logic             r_wrap;
   logic [WIDTH-1:0] w_step_up;
   logic [WIDTH-1:0] w_step_dn;
   logic [WIDTH-1:0] w_load_code;
   logic [31:0]      w_lp;
   logic [31:0]      w_pop;
   logic [WIDTH-1:0] w_next_count;
   logic             w_next_wrap;

   // One-position shifts of the twisted ring in each direction
   assign w_step_up = {~r_count[0], r_count[WIDTH-1:1]};
   assign w_step_dn = {r_count[WIDTH-2:0], ~r_count[WIDTH-1]};
   assign w_lp      = 32'(bus.load_phase);

   // Legal code for the requested phase: ones fill from the MSB for the first
   // half of the sequence, then drain leaving ones at the LSB end
   always_comb begin
      w_load_code = '0;
      if (w_lp == 32'd0 || w_lp >= C_LEN)
         w_load_code = '0;
      else if (w_lp <= 32'(WIDTH))
         w_load_code = ~(C_ONES >> w_lp);
      else
         w_load_code = C_ONES >> (w_lp - 32'(WIDTH));
   end

   // Population count of the current code, used by the phase decoder
   always_comb begin
      w_pop = '0;
      for (int i = 0; i < WIDTH; i++)
         w_pop = w_pop + 32'(r_count[i]);
   end

`ifdef JOHNSON_SELF_CORRECT_EN
   logic        r_illegal;
   logic        w_next_illegal;
   logic [31:0] w_trans;

   // Count adjacent-bit transitions; a legal Johnson code has at most one
   always_comb begin
      w_trans = '0;
      for (int i = 0; i < WIDTH - 1; i++)
         w_trans = w_trans + 32'(r_count[i] ^ r_count[i+1]);
   end

   // Next-state selection: load, then correction, then step, else hold
   always_comb begin
      w_next_count   = r_count;
      w_next_wrap    = 1'b0;
      w_next_illegal = 1'b0;
      if (bus.load) begin
         w_next_count = w_load_code;
         w_next_wrap  = (r_count != '0) && (w_load_code == '0);
      end else if (w_trans > 32'd1) begin
         w_next_count   = '0;
         w_next_illegal = 1'b1;
      end else if (bus.en) begin
         w_next_count = bus.dir ? w_step_up : w_step_dn;
         w_next_wrap  = (r_count != '0) && (w_next_count == '0);
      end
   end

   // Illegal strobe register
   always_ff @(posedge clk) begin
      if (rst) r_illegal <= 1'b0;
      else     r_illegal <= w_next_illegal;
   end

   assign bus.illegal = r_illegal;
`else
   // Next-state selection: load, then step, else hold (no legality check)
   always_comb begin
      w_next_count = r_count;
      w_next_wrap  = 1'b0;
      if (bus.load) begin
         w_next_count = w_load_code;
         w_next_wrap  = (r_count != '0) && (w_load_code == '0);
      end else if (bus.en) begin
         w_next_count = bus.dir ? w_step_up : w_step_dn;
         w_next_wrap  = (r_count != '0) && (w_next_count == '0);
      end
   end

   assign bus.illegal = 1'b0;
`endif

   // Code and wrap strobe registers
   always_ff @(posedge clk) begin
      if (rst) begin
         r_count <= '0;
         r_wrap  <= 1'b0;
      end else begin
         r_count <= w_next_count;
         r_wrap  <= w_next_wrap;
      end
   end

   assign bus.count = r_count;
   assign bus.wrap  = r_wrap;

   // Phase decode: MSB set means still filling (phase = ones), otherwise
   // draining (phase = 2*WIDTH - ones); all-zero is phase 0
   assign bus.phase = (r_count == '0)     ? '0 :
                      r_count[WIDTH-1]    ? PW'(w_pop) :
                                            PW'(C_LEN - w_pop);
endmodule

`default_nettype wire

// File: tb/tb_johnson_counter_param.sv
// ============================================================================
//  Module      : tb_johnson_counter_param
//  Description : Self-checking bench for johnson_counter_param at WIDTH 2, 4,
//                5 and 32. Table-driven vectors on the 4-bit instance plus
//                hand-written load, illegal-code and full-cycle sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_johnson_counter_param;
   logic clk = 1'b0;
   logic rst;
   int   checks   = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   johnson_counter_param_if #(.WIDTH(4))  b4  ();
   johnson_counter_param_if #(.WIDTH(5))  b5  ();
   johnson_counter_param_if #(.WIDTH(2))  b2  ();
   johnson_counter_param_if #(.WIDTH(32)) b32 ();

   johnson_counter_param #(.WIDTH(4))  u4  (.clk(clk), .rst(rst), .bus(b4));
   johnson_counter_param #(.WIDTH(5))  u5  (.clk(clk), .rst(rst), .bus(b5));
   johnson_counter_param #(.WIDTH(2))  u2  (.clk(clk), .rst(rst), .bus(b2));
   johnson_counter_param #(.WIDTH(32)) u32 (.clk(clk), .rst(rst), .bus(b32));

   typedef struct {
      logic       rst;
      logic       en;
      logic       dir;
      logic       load;
      logic [2:0] lp;
      logic [3:0] cnt;
      logic [2:0] ph;
      logic       wrap;
   } vec_t;

   localparam int NV = 29;
   vec_t tbl [NV];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   int nwrap;

   initial begin
      rst = 1'b1;
      b4.en = 1'b0;  b4.dir = 1'b0;  b4.load = 1'b0;  b4.load_phase = '0;
      b5.en = 1'b0;  b5.dir = 1'b0;  b5.load = 1'b0;  b5.load_phase = '0;
      b2.en = 1'b0;  b2.dir = 1'b0;  b2.load = 1'b0;  b2.load_phase = '0;
      b32.en = 1'b0; b32.dir = 1'b0; b32.load = 1'b0; b32.load_phase = '0;

      //          rst   en    dir   load  lp     cnt       ph     wrap
      tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 4'b0000, 3'd0, 1'b0};
      // up cycle
      tbl[1]  = '{1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 4'b1000, 3'd1, 1'b0};
      tbl[2]  = '{1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 4'b1100, 3'd2, 1'b0};
      tbl[3]  = '{1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 4'b1110, 3'd3, 1'b0};
      tbl[4]  = '{1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 4'b1111, 3'd4, 1'b0};
      tbl[5]  = '{1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 4'b0111, 3'd5, 1'b0};
      tbl[6]  = '{1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 4'b0011, 3'd6, 1'b0};
      tbl[7]  = '{1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 4'b0001, 3'd7, 1'b0};
      tbl[8]  = '{1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 4'b0000, 3'd0, 1'b1};
      // down cycle
      tbl[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 4'b0001, 3'd7, 1'b0};
      tbl[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 4'b0011, 3'd6, 1'b0};
      tbl[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 4'b0111, 3'd5, 1'b0};
      tbl[12] = '{1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 4'b1111, 3'd4, 1'b0};
      tbl[13] = '{1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 4'b1110, 3'd3, 1'b0};
      tbl[14] = '{1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 4'b1100, 3'd2, 1'b0};
      tbl[15] = '{1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 4'b1000, 3'd1, 1'b0};
      tbl[16] = '{1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 4'b0000, 3'd0, 1'b1};
      // load phase 3, hold three edges, then step down
      tbl[17] = '{1'b0, 1'b0, 1'b1, 1'b1, 3'd3, 4'b1110, 3'd3, 1'b0};
      tbl[18] = '{1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 4'b1110, 3'd3, 1'b0};
      tbl[19] = '{1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 4'b1110, 3'd3, 1'b0};
      tbl[20] = '{1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 4'b1110, 3'd3, 1'b0};
      tbl[21] = '{1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 4'b1100, 3'd2, 1'b0};
      // rst concurrent with load
      tbl[22] = '{1'b1, 1'b1, 1'b1, 1'b1, 3'd5, 4'b0000, 3'd0, 1'b0};
      // load to phase 6, then load to 0 produces wrap
      tbl[23] = '{1'b0, 1'b0, 1'b0, 1'b1, 3'd6, 4'b0011, 3'd6, 1'b0};
      tbl[24] = '{1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 4'b0000, 3'd0, 1'b1};
      // up then down from phase 1 wraps
      tbl[25] = '{1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 4'b1000, 3'd1, 1'b0};
      tbl[26] = '{1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 4'b0000, 3'd0, 1'b1};
      // load beats en/dir
      tbl[27] = '{1'b0, 1'b1, 1'b0, 1'b1, 3'd2, 4'b1100, 3'd2, 1'b0};
      // rst mid-sequence
      tbl[28] = '{1'b1, 1'b1, 1'b1, 1'b0, 3'd0, 4'b0000, 3'd0, 1'b0};

      tick();
      tick();

      for (int i = 0; i < NV; i++) begin
         rst           = tbl[i].rst;
         b4.en         = tbl[i].en;
         b4.dir        = tbl[i].dir;
         b4.load       = tbl[i].load;
         b4.load_phase = tbl[i].lp;
         tick();
         chk($sformatf("v%0d.count", i),   64'(b4.count),   64'(tbl[i].cnt));
         chk($sformatf("v%0d.phase", i),   64'(b4.phase),   64'(tbl[i].ph));
         chk($sformatf("v%0d.wrap", i),    64'(b4.wrap),    64'(tbl[i].wrap));
         chk($sformatf("v%0d.illegal", i), 64'(b4.illegal), 64'd0);
      end
      rst = 1'b0;
      b4.en = 1'b0; b4.load = 1'b0;
      tick();

      // WIDTH=5 load: phase 7 then out-of-range 12 -> 0 with wrap
      b5.load = 1'b1; b5.load_phase = 4'd7;
      tick();
      chk("w5.load7.count", 64'(b5.count), 64'b00111);
      chk("w5.load7.phase", 64'(b5.phase), 64'd7);
      chk("w5.load7.wrap",  64'(b5.wrap),  64'd0);
      b5.load_phase = 4'd12;
      tick();
      chk("w5.load12.count", 64'(b5.count), 64'd0);
      chk("w5.load12.phase", 64'(b5.phase), 64'd0);
      chk("w5.load12.wrap",  64'(b5.wrap),  64'd1);
      b5.load = 1'b0;
      tick();
      chk("w5.wrap_clear", 64'(b5.wrap), 64'd0);

      // Illegal code 1010 planted directly into the 4-bit counter
      force u4.r_count = 4'b1010;
      #1;
      release u4.r_count;
      b4.en = 1'b1; b4.dir = 1'b1;
      #1;
      chk("ill.phase_before", 64'(b4.phase), 64'd2);
      tick();
`ifdef JOHNSON_SELF_CORRECT_EN
      chk("ill.count",   64'(b4.count),   64'b0000);
      chk("ill.illegal", 64'(b4.illegal), 64'd1);
      chk("ill.wrap",    64'(b4.wrap),    64'd0);
      tick();
      chk("ill.count2",   64'(b4.count),   64'b1000);
      chk("ill.illegal2", 64'(b4.illegal), 64'd0);
`else
      chk("ill.count",   64'(b4.count),   64'b1101);
      chk("ill.illegal", 64'(b4.illegal), 64'd0);
      chk("ill.wrap",    64'(b4.wrap),    64'd0);
      tick();
      chk("ill.count2",   64'(b4.count),   64'b0110);
      chk("ill.illegal2", 64'(b4.illegal), 64'd0);
`endif
      b4.en = 1'b0;

      // WIDTH=2 full up cycle
      nwrap = 0;
      b2.en = 1'b1; b2.dir = 1'b1;
      for (int k = 0; k < 4; k++) begin
         tick();
         chk($sformatf("w2.phase%0d", k), 64'(b2.phase), 64'((k + 1) % 4));
         nwrap += int'(b2.wrap);
      end
      b2.en = 1'b0;
      chk("w2.count_end", 64'(b2.count), 64'd0);
      chk("w2.wraps",     64'(nwrap),    64'd1);

      // WIDTH=32 full up cycle
      nwrap = 0;
      b32.en = 1'b1; b32.dir = 1'b1;
      for (int k = 0; k < 64; k++) begin
         tick();
         chk($sformatf("w32.phase%0d", k), 64'(b32.phase), 64'((k + 1) % 64));
         nwrap += int'(b32.wrap);
         if (k == 31) chk("w32.all_ones", 64'(b32.count), 64'hFFFF_FFFF);
      end
      b32.en = 1'b0;
      chk("w32.count_end", 64'(b32.count), 64'd0);
      chk("w32.wraps",     64'(nwrap),     64'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

`default_nettype wire
